// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate/target generator.
package imm_pkg;

  // Widest supported datapath; per-lane results are carried at this width.
  localparam int unsigned XLEN_MAX       = 64;
  localparam int unsigned LANE_PC_STRIDE = 4;
  localparam int unsigned IMM_SRC_W      = 3;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  // imm/target hold the XLEN-wide value in the low bits, upper bits zero.
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    logic [XLEN_MAX-1:0] target;
    logic                illegal;
  } lane_result_t;

endpackage

// File: rtl/imm_lane_decode.sv
// Per-lane immediate extraction and PC-relative target computation.
module imm_lane_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) (
  input  logic [ILEN-1:0]      instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  input  logic                 lane_en,
  input  logic [XLEN-1:0]      lane_pc,
  output lane_result_t         result
);

  logic [31:0]     imm32;
  logic            legal;
  logic [XLEN-1:0] imm_x;
  logic [6:0]      unused_opcode;

  // Opcode bits never contribute to any immediate.
  assign unused_opcode = instr[6:0];

  // Assemble the 32-bit immediate for the selected format.
  always_comb begin
    imm32 = '0;
    legal = 1'b1;
    case (imm_src_e'(imm_src))
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      default: legal = 1'b0;
    endcase
  end

  // Every 32-bit immediate carries its sign in bit 31, so one extension suffices.
  assign imm_x = XLEN'($signed(imm32));

  // Masked lanes are all-zero; illegal formats pass the lane PC through.
  always_comb begin
    result = '0;
    if (lane_en) begin
      if (legal) begin
        result.imm    = XLEN_MAX'(imm_x);
        result.target = XLEN_MAX'(lane_pc + imm_x);
      end else begin
        result.target = XLEN_MAX'(lane_pc);
      end
      result.illegal = ~legal;
    end
  end

endmodule

// File: rtl/imm_target_gen.sv
// Multi-lane immediate/target generator with a registered skid-buffered output.
module imm_target_gen
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned LANES = 2,
  parameter int unsigned ILEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ILEN-1:0]    in_instr,
  input  logic [LANES*IMM_SRC_W-1:0] in_imm_src,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [LANES-1:0]         in_lane_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*XLEN-1:0]    out_imm,
  output logic [LANES*XLEN-1:0]    out_target,
  output logic [LANES-1:0]         out_illegal,
  output logic [LANES-1:0]         out_lane_en
);

  // Encoding is {main_valid, skid_valid}; 2'b01 must never occur.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } state_e;

  state_e state_q, state_d;
  logic   main_valid, skid_valid;
  logic   main_load_in, main_load_skid, skid_load;

  lane_result_t dec_res [LANES];
  logic [LANES*XLEN-1:0] dec_imm, dec_target;
  logic [LANES-1:0]      dec_illegal;

  logic [LANES*XLEN-1:0] main_imm_q, main_target_q, skid_imm_q, skid_target_q;
  logic [LANES-1:0]      main_illegal_q, main_lane_en_q, skid_illegal_q, skid_lane_en_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [XLEN-1:0] lane_pc;
    assign lane_pc = in_pc + XLEN'(LANE_PC_STRIDE * i);

    imm_lane_decode #(
      .XLEN(XLEN),
      .ILEN(ILEN)
    ) u_decode (
      .instr  (in_instr[i*ILEN +: ILEN]),
      .imm_src(in_imm_src[i*IMM_SRC_W +: IMM_SRC_W]),
      .lane_en(in_lane_en[i]),
      .lane_pc(lane_pc),
      .result (dec_res[i])
    );

    assign dec_imm[i*XLEN +: XLEN]    = dec_res[i].imm[XLEN-1:0];
    assign dec_target[i*XLEN +: XLEN] = dec_res[i].target[XLEN-1:0];
    assign dec_illegal[i]             = dec_res[i].illegal;

    // Upper result bits are always zero below the widest XLEN.
    if (XLEN < XLEN_MAX) begin : g_hi
      logic [2*(XLEN_MAX-XLEN)-1:0] unused_hi;
      assign unused_hi = {dec_res[i].imm[XLEN_MAX-1:XLEN], dec_res[i].target[XLEN_MAX-1:XLEN]};
    end
  end

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: occupancy of the two-entry output stage.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (in_valid) state_d = StOne;
      StOne: begin
        if (in_valid && !out_ready) begin
          state_d = StFull;
        end else if (!in_valid && out_ready) begin
          state_d = StEmpty;
        end
      end
      StFull:  if (out_ready) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  // Outputs: handshake and register load enables; in_ready depends on state only.
  always_comb begin
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      StEmpty: begin
        in_ready     = 1'b1;
        main_load_in = in_valid;
      end
      StOne: begin
        in_ready     = 1'b1;
        out_valid    = 1'b1;
        main_load_in = in_valid && out_ready;
        skid_load    = in_valid && !out_ready;
      end
      StFull: begin
        out_valid      = 1'b1;
        main_load_skid = out_ready;
      end
      default: ;
    endcase
  end

  // Data registers: main feeds the outputs, skid catches one bundle under back-pressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_imm_q     <= '0;
      main_target_q  <= '0;
      main_illegal_q <= '0;
      main_lane_en_q <= '0;
      skid_imm_q     <= '0;
      skid_target_q  <= '0;
      skid_illegal_q <= '0;
      skid_lane_en_q <= '0;
    end else begin
      if (main_load_skid) begin
        main_imm_q     <= skid_imm_q;
        main_target_q  <= skid_target_q;
        main_illegal_q <= skid_illegal_q;
        main_lane_en_q <= skid_lane_en_q;
      end else if (main_load_in) begin
        main_imm_q     <= dec_imm;
        main_target_q  <= dec_target;
        main_illegal_q <= dec_illegal;
        main_lane_en_q <= in_lane_en;
      end
      if (skid_load) begin
        skid_imm_q     <= dec_imm;
        skid_target_q  <= dec_target;
        skid_illegal_q <= dec_illegal;
        skid_lane_en_q <= in_lane_en;
      end
    end
  end

  assign out_imm     = main_imm_q;
  assign out_target  = main_target_q;
  assign out_illegal = main_illegal_q;
  assign out_lane_en = main_lane_en_q;

  a_no_skid_without_main: assert property (@(posedge clk) disable iff (!rst_n)
    !(skid_valid && !main_valid));

  a_hold_under_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(out_imm) && $stable(out_target) &&
                                   $stable(out_illegal) && $stable(out_lane_en)));

endmodule
